// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter generator.
//   pc_src_e          - next-PC source selector, in descending priority order
//                       TRAP > MRET > RET > REDIR > SEQ (stall is a hold, not a source)
//   DEFAULT_*         - default vectors, RAS depth and instruction size
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEFAULT_RAS_DEPTH    = 4;
  localparam int unsigned DEFAULT_INSTR_BYTES  = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_REDIR,
    SRC_RET,
    SRC_MRET,
    SRC_TRAP
  } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: control and status bundle between the core's branch/control
// logic and the PC generator.
//   master : core side - drives stall/redirect/call/ret/trap/mret and targets,
//            observes pc_out, pc_plus, epc_out, RAS flags and misaligned
//   slave  : pc_gen side - the mirror image
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] ret_target;
  logic            trap;
  logic            mret;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] epc_out;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;

  modport master (
    output stall, redirect, redirect_target, call, ret, ret_target, trap, mret,
    input  pc_out, pc_plus, epc_out, ras_empty, ras_full, misaligned
  );

  modport slave (
    input  stall, redirect, redirect_target, call, ret, ret_target, trap, mret,
    output pc_out, pc_plus, epc_out, ras_empty, ras_full, misaligned
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst   : clock, asynchronous active-high reset (pointer/count only;
//                entry storage is never cleared)
//   push, pop  : push only writes push_data above the top; pop only drops
//                the top; both together replace the top entry in place
//   push_data  : return address to store
//   top_data   : current top entry (meaningless while empty)
//   empty/full : count == 0 / count == RAS_DEPTH
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_data = mem_q[top_q];

  // Pushing when full lets the pointer wrap onto the oldest entry, so the
  // buffer behaves as a circular stack without any explicit eviction.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (push && pop) begin
      wr_en  = 1'b1;
      wr_idx = top_q;
      if (empty) cnt_d = CNT_W'(1);
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = top_q + PTR_W'(1);
      top_d  = top_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter and next-PC selection for the single-cycle core.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_gen_if slave port
//     inputs  stall, redirect/redirect_target, call, ret/ret_target, trap, mret
//     outputs pc_out (fetch address), pc_plus (pc_out + INSTR_BYTES),
//             epc_out, ras_empty, ras_full, misaligned (one-cycle pulse)
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH,
  parameter int unsigned     INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ret_tgt;
  logic [XLEN-1:0] sel_tgt;
  logic            tgt_mis;
  pc_src_e         src;

  assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    src = SRC_SEQ;
    if      (bus.trap)     src = SRC_TRAP;
    else if (bus.mret)     src = SRC_MRET;
    else if (bus.ret)      src = SRC_RET;
    else if (bus.redirect) src = SRC_REDIR;

    ret_tgt = ras_empty ? bus.ret_target : ras_top;
    sel_tgt = (src == SRC_RET) ? ret_tgt : bus.redirect_target;
    tgt_mis = ((src == SRC_RET) || (src == SRC_REDIR)) &&
              ((sel_tgt % XLEN'(INSTR_BYTES)) != '0);

    pc_d     = pc_plus;
    epc_d    = epc_q;
    mis_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;

    // Trap wins over stall; a misaligned target is turned into a trap and
    // suppresses the RAS update. RAS push/pop follow call/ret independently
    // of which source ends up driving the PC.
    if (src == SRC_TRAP) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (tgt_mis) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
      mis_d = 1'b1;
    end else begin
      ras_push = bus.call;
      ras_pop  = bus.ret;
      unique case (src)
        SRC_MRET:  pc_d = epc_q;
        SRC_RET:   pc_d = ret_tgt;
        SRC_REDIR: pc_d = bus.redirect_target;
        default:   pc_d = pc_plus;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.pc_plus    = pc_plus;
  assign bus.epc_out    = epc_q;
  assign bus.ras_empty  = ras_empty;
  assign bus.ras_full   = ras_full;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        empty;
    logic        full;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        exp_q[$];
  logic [31:0] m_ras[$];   // back of queue = top of stack
  logic [31:0] m_pc;
  logic [31:0] m_epc;

  pc_gen_if #(.XLEN(32)) bus();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .RAS_DEPTH    (DEPTH),
    .INSTR_BYTES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // Monitor: one DUT output per clock while out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc_out",     bus.pc_out,            e.pc);
      chk("pc_plus",    bus.pc_plus,           e.pc + 32'd4);
      chk("epc_out",    bus.epc_out,           e.epc);
      chk("ras_empty",  32'(bus.ras_empty),    32'(e.empty));
      chk("ras_full",   32'(bus.ras_full),     32'(e.full));
      chk("misaligned", 32'(bus.misaligned),   32'(e.mis));
    end
  end

  task automatic model_reset();
    m_pc  = RV;
    m_epc = RV;
    m_ras.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_pc"},    bus.pc_out,          RV);
    chk({tag, "_epc"},   bus.epc_out,         RV);
    chk({tag, "_empty"}, 32'(bus.ras_empty),  32'd1);
    chk({tag, "_full"},  32'(bus.ras_full),   32'd0);
    chk({tag, "_mis"},   32'(bus.misaligned), 32'd0);
  endtask

  // Called at a negedge; drives one cycle of inputs, predicts, returns at next negedge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rdt,
                      input logic ca, input logic rt, input logic [31:0] rtt,
                      input logic tr, input logic mr);
    logic [31:0] nxt, tgt, pcp;
    logic        bad, chkd;
    exp_t        e;
    bus.stall = st; bus.redirect = rd; bus.redirect_target = rdt;
    bus.call = ca; bus.ret = rt; bus.ret_target = rtt;
    bus.trap = tr; bus.mret = mr;

    pcp = m_pc + 32'd4;
    e.mis = 1'b0;
    if (tr) begin
      m_epc = m_pc;
      m_pc  = TV;
    end else if (!st) begin
      chkd = 1'b0;
      tgt  = pcp;
      if (mr) tgt = m_epc;
      else if (rt) begin tgt = (m_ras.size() > 0) ? m_ras[$] : rtt; chkd = 1'b1; end
      else if (rd) begin tgt = rdt; chkd = 1'b1; end
      bad = chkd && (tgt[1:0] != 2'b00);
      if (bad) begin
        m_epc = m_pc;
        m_pc  = TV;
        e.mis = 1'b1;
      end else begin
        if (ca && rt) begin
          if (m_ras.size() == 0) m_ras.push_back(pcp);
          else m_ras[m_ras.size()-1] = pcp;
        end else if (ca) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(pcp);
        end else if (rt && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
        nxt  = tgt;
        m_pc = nxt;
      end
    end
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] t);
    step(0, 1, t, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted away from any clock edge; checked immediately.
  task automatic mid_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;
    bus.call = 0; bus.ret = 0; bus.ret_target = 0;
    bus.trap = 0; bus.mret = 0;
    model_reset();
    #1 check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free-running, then asynchronous reset mid-cycle.
    repeat (3) idle();
    mid_reset();

    // Stall holds PC even with a redirect pending.
    redir(32'h10);
    step(1, 1, 32'h80, 0, 0, 0, 0, 0);
    step(1, 1, 32'h80, 0, 0, 0, 0, 0);
    redir(32'h40);

    // Five calls overflow a 4-deep RAS; four rets unwind, fifth uses ret_target.
    redir(32'h100);
    step(0, 1, 32'h200, 1, 0, 0, 0, 0);
    step(0, 1, 32'h300, 1, 0, 0, 0, 0);
    step(0, 1, 32'h400, 1, 0, 0, 0, 0);
    step(0, 1, 32'h500, 1, 0, 0, 0, 0);
    step(0, 1, 32'h600, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1, 32'h888, 0, 0);

    // Trap during stall, then mret.
    redir(32'h20);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Misaligned redirect, then a misaligned call+redirect that must not push.
    redir(32'h30);
    redir(32'h42);
    idle();
    step(0, 1, 32'h46, 1, 0, 0, 0, 0);
    idle();

    // Co-routine call+ret replaces the top entry.
    redir(32'h600);
    step(0, 1, 32'h700, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h888, 0, 0);
    step(0, 0, 0, 0, 1, 32'h888, 0, 0);

    // Sequential wrap at the top of the address space.
    redir(32'hFFFF_FFFC);
    idle();
    idle();

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      a = $urandom() & 32'hFFFF_FFFC;
      b = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) b = b | 32'($urandom_range(1, 3));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, a,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, b,
           $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
